adder_bist_ctrl: RTL



---
 rtl/adder_bist_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/adder_bist_ctrl.sv
// adder_bist_ctrl: drives exhaustive operand pairs into a combinational
// adder, compacts {carry, sum} into a MISR signature and, when the macro
// BIST_GOLDEN_CHECK_EN is defined, counts mismatches against a behavioural
// golden add (err_cnt saturates at 16'hFFFF; it is tied to zero otherwise).
module adder_bist_ctrl #(
  parameter int               WIDTH       = 7,
  parameter int               NUM_VECTORS = 2**(2*WIDTH),
  parameter logic [WIDTH:0]   POLY        = 8'h1D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] o_add_term1,
  output logic [WIDTH-1:0] o_add_term2,
  input  logic [WIDTH-1:0] i_sum,
  input  logic             i_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   signature,
  output logic [15:0]      err_cnt
);

  localparam int             CW   = 2*WIDTH;
  localparam logic [CW-1:0]  LAST = CW'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [WIDTH:0]  sig_q,   sig_d;

  // One MISR step: shift left, fold the MSB back through POLY, absorb data.
  function automatic logic [WIDTH:0] misr_next(input logic [WIDTH:0] sig,
                                               input logic [WIDTH:0] din);
    misr_next = {sig[WIDTH-1:0], 1'b0} ^ ({(WIDTH+1){sig[WIDTH]}} & POLY) ^ din;
  endfunction

  // Operands come straight from the counter flops: high half is A, low half is B.
  assign o_add_term1 = cnt_q[CW-1:WIDTH];
  assign o_add_term2 = cnt_q[WIDTH-1:0];
  assign signature   = sig_q;

`ifdef BIST_GOLDEN_CHECK_EN
  logic [15:0] err_q, err_d;

  // Behavioural reference for the adder under test, carry included.
  function automatic logic [WIDTH:0] golden_add(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    golden_add = {1'b0, a} + {1'b0, b};
  endfunction

  assign err_cnt = err_q;

  // Mismatch counter: cleared on an accepted start, saturating during RUN.
  always_comb begin
    err_d = err_q;
    if (state_q == IDLE && start) begin
      err_d = '0;
    end else if (state_q == RUN) begin
      if (golden_add(o_add_term1, o_add_term2) != {i_cout, i_sum} &&
          err_q != 16'hFFFF) begin
        err_d = err_q + 16'd1;
      end
    end
  end

  // Mismatch counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end
`else
  assign err_cnt = '0;
`endif

  // Next-state, counter and signature logic; busy/done decode the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          sig_d   = '0;
        end
      end
      RUN: begin
        busy  = 1'b1;
        sig_d = misr_next(sig_q, {i_cout, i_sum});
        // Terminal test precedes the increment, so the counter never wraps
        // and the operands keep the last applied pair.
        if (cnt_q == LAST) state_d = DONE;
        else               cnt_d   = cnt_q + 1'b1;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and signature registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
    end
  end

endmodule
